// File: rtl/pw_attempt_ctrl_if.sv
// Signal bundle between the password check controller and its environment.
// The master drives the tick/switch/code inputs; the slave (the controller) drives the status outputs.
interface pw_attempt_ctrl_if #(
    parameter int unsigned FAIL_W  = 2,
    parameter int unsigned TIMER_W = 8
);
    logic               tick;
    logic               ok;
    logic               set_busy;
    logic [15:0]        code_in;
    logic [15:0]        pw_stored;
    logic [1:0]         pw_match;
    logic               unlock;
    logic               locked;
    logic [FAIL_W-1:0]  fail_cnt;
    logic [TIMER_W-1:0] lock_remaining;

    modport master (
        output tick, ok, set_busy, code_in, pw_stored,
        input  pw_match, unlock, locked, fail_cnt, lock_remaining
    );

    modport slave (
        input  tick, ok, set_busy, code_in, pw_stored,
        output pw_match, unlock, locked, fail_cnt, lock_remaining
    );
endinterface

// File: rtl/pw_attempt_ctrl.sv
// Password attempt sequencer: latches the entered code on an ok rising edge, compares it with the
// stored code, shows PASS/FAIL for a timed interval and enforces a lockout after repeated failures.
module pw_attempt_ctrl #(
    parameter int unsigned MAX_FAIL     = 3,
    parameter int unsigned FAIL_W       = 2,
    parameter int unsigned LOCK_TICKS   = 30,
    parameter int unsigned RESULT_TICKS = 5,
    parameter int unsigned TIMER_W      = 8
) (
    input logic                clk,
    input logic                rst,
    pw_attempt_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCheck  = 3'd1,
        StPass   = 3'd2,
        StFail   = 3'd3,
        StLocked = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [FAIL_W-1:0]  fail_q, fail_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [15:0]        code_q, code_d;
    logic               ok_q;
    logic               rise;
    logic [FAIL_W:0]    fail_next;

    assign rise      = bus.ok & ~ok_q;
    assign fail_next = {1'b0, fail_q} + {{FAIL_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            fail_q  <= '0;
            timer_q <= '0;
            code_q  <= '0;
            // Starts high so an ok held across reset release is not seen as a press.
            ok_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            ok_q    <= bus.ok;
        end
    end

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        code_d  = code_q;
        unique case (state_q)
            StIdle: begin
                if (rise && !bus.set_busy) begin
                    code_d  = bus.code_in;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (code_q == bus.pw_stored) begin
                    fail_d  = '0;
                    timer_d = TIMER_W'(RESULT_TICKS);
                    state_d = StPass;
                end else if (fail_next == (FAIL_W+1)'(MAX_FAIL)) begin
                    fail_d  = FAIL_W'(MAX_FAIL);
                    timer_d = TIMER_W'(LOCK_TICKS);
                    state_d = StLocked;
                end else begin
                    fail_d  = fail_next[FAIL_W-1:0];
                    timer_d = TIMER_W'(RESULT_TICKS);
                    state_d = StFail;
                end
            end
            StPass, StFail, StLocked: begin
                if (bus.tick) begin
                    timer_d = timer_q - TIMER_W'(1);
                    if (timer_q == TIMER_W'(1)) begin
                        state_d = StIdle;
                        if (state_q == StLocked) begin
                            fail_d = '0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.pw_match       = 2'b00;
        bus.unlock         = 1'b0;
        bus.locked         = 1'b0;
        bus.lock_remaining = '0;
        bus.fail_cnt       = fail_q;
        unique case (state_q)
            StPass: begin
                bus.pw_match = 2'b01;
                bus.unlock   = 1'b1;
            end
            StFail: bus.pw_match = 2'b10;
            StLocked: begin
                bus.pw_match       = 2'b11;
                bus.locked         = 1'b1;
                bus.lock_remaining = timer_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pw_attempt_ctrl.sv
// Directed bench for pw_attempt_ctrl: pass/fail display, lockout, edge detection, reset and latching.
module tb_pw_attempt_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pw_attempt_ctrl_if #(.FAIL_W(2), .TIMER_W(8)) bus ();

    pw_attempt_ctrl #(
        .MAX_FAIL     (3),
        .FAIL_W       (2),
        .LOCK_TICKS   (30),
        .RESULT_TICKS (5),
        .TIMER_W      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [15:0] Good = 16'h1234;
    localparam logic [15:0] Bad  = 16'h1111;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks every output against the expected status encoding.
    task automatic chk_out(input string tag, input logic [1:0] m, input logic [1:0] f,
                           input logic [7:0] rem);
        chk({tag, ".pw_match"}, 32'(bus.pw_match), 32'(m));
        chk({tag, ".unlock"}, 32'(bus.unlock), 32'(m == 2'b01));
        chk({tag, ".locked"}, 32'(bus.locked), 32'(m == 2'b11));
        chk({tag, ".fail_cnt"}, 32'(bus.fail_cnt), 32'(f));
        chk({tag, ".lock_remaining"}, 32'(bus.lock_remaining), 32'(rem));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
        end
    endtask

    // Rising edge of ok with code c; returns once the result state is visible.
    task automatic press(input logic [15:0] c);
        bus.code_in = c;
        bus.ok      = 1'b1;
        step(2);
        bus.ok      = 1'b0;
    endtask

    initial begin
        bus.tick      = 1'b0;
        bus.ok        = 1'b0;
        bus.set_busy  = 1'b0;
        bus.code_in   = 16'h0000;
        bus.pw_stored = Good;
        step(2);
        chk_out("reset", 2'b00, 2'd0, 8'd0);
        rst = 1'b0;
        step();

        // 1: correct code, check latency and result duration
        bus.code_in = Good;
        bus.ok      = 1'b1;
        step();
        chk_out("t1_check", 2'b00, 2'd0, 8'd0);
        step();
        chk_out("t1_pass", 2'b01, 2'd0, 8'd0);
        bus.ok = 1'b0;
        ticks(4);
        chk_out("t1_pass_4t", 2'b01, 2'd0, 8'd0);
        ticks(1);
        chk_out("t1_idle", 2'b00, 2'd0, 8'd0);

        // 2: three failures lock out, further presses ignored, lockout expires
        press(Bad);
        chk_out("t2_fail1", 2'b10, 2'd1, 8'd0);
        ticks(5);
        chk_out("t2_idle1", 2'b00, 2'd1, 8'd0);
        press(Bad);
        chk_out("t2_fail2", 2'b10, 2'd2, 8'd0);
        ticks(5);
        press(Bad);
        chk_out("t2_lock", 2'b11, 2'd3, 8'd30);
        step();
        press(Good);
        chk_out("t2_lock_okign", 2'b11, 2'd3, 8'd30);
        ticks(29);
        chk_out("t2_lock_29t", 2'b11, 2'd3, 8'd1);
        ticks(1);
        chk_out("t2_unlocked", 2'b00, 2'd0, 8'd0);

        // 3: two failures then a correct code clears the count
        press(Bad);
        ticks(5);
        press(Bad);
        chk_out("t3_fail2", 2'b10, 2'd2, 8'd0);
        ticks(5);
        press(Good);
        chk_out("t3_pass", 2'b01, 2'd0, 8'd0);
        ticks(5);

        // 4: held ok gives one check only; rise during set_busy is dropped
        bus.code_in = Bad;
        bus.ok      = 1'b1;
        step(2);
        chk_out("t4_fail", 2'b10, 2'd1, 8'd0);
        ticks(5);
        step(90);
        chk_out("t4_held", 2'b00, 2'd1, 8'd0);
        bus.ok = 1'b0;
        step();
        bus.set_busy = 1'b1;
        bus.ok       = 1'b1;
        step(3);
        chk_out("t4_busy", 2'b00, 2'd1, 8'd0);
        bus.set_busy = 1'b0;
        step(3);
        chk_out("t4_busy_rel", 2'b00, 2'd1, 8'd0);
        bus.ok = 1'b0;
        step();

        // 5: reset in the middle of a lockout, ok held across release
        press(Bad);
        chk_out("t5_fail2", 2'b10, 2'd2, 8'd0);
        ticks(5);
        press(Bad);
        chk_out("t5_lock", 2'b11, 2'd3, 8'd30);
        ticks(13);
        chk_out("t5_lock17", 2'b11, 2'd3, 8'd17);
        rst      = 1'b1;
        bus.tick = 1'b1;
        bus.ok   = 1'b1;
        step();
        bus.tick = 1'b0;
        chk_out("t5_reset", 2'b00, 2'd0, 8'd0);
        rst = 1'b0;
        step(3);
        chk_out("t5_ok_held", 2'b00, 2'd0, 8'd0);
        bus.ok = 1'b0;
        step();

        // 6: tick on the rise and CHECK cycles; code changed after latching
        bus.code_in = Good;
        bus.ok      = 1'b1;
        bus.tick    = 1'b1;
        step();
        bus.code_in = 16'h0000;
        step();
        bus.tick = 1'b0;
        bus.ok   = 1'b0;
        chk_out("t6_pass", 2'b01, 2'd0, 8'd0);
        ticks(4);
        chk_out("t6_pass_4t", 2'b01, 2'd0, 8'd0);
        ticks(1);
        chk_out("t6_idle", 2'b00, 2'd0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
